// File: rtl/irq_controller_if.sv
// irq_controller_if: interrupt sources, CSR window and core handshake of the interrupt controller
interface irq_controller_if #(
  parameter int XLEN = 32
) ();
  logic            timer_interrupt;
  logic            ext_irq;
  logic            sw_irq_set;
  logic            csr_we;
  logic [1:0]      csr_sel;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            irq_req;
  logic [XLEN-1:0] irq_cause;
  logic            irq_ack;
  logic            mret;
  modport master (
    output timer_interrupt, ext_irq, sw_irq_set, csr_we, csr_sel, csr_wdata, irq_ack, mret,
    input  csr_rdata, irq_req, irq_cause
  );
  modport slave (
    input  timer_interrupt, ext_irq, sw_irq_set, csr_we, csr_sel, csr_wdata, irq_ack, mret,
    output csr_rdata, irq_req, irq_cause
  );
endinterface

// File: rtl/irq_controller.sv
// irq_controller: masks and prioritises machine interrupts and hands one held request to the core
module irq_controller #(
  parameter int XLEN        = 32,
  parameter int SYNC_STAGES = 2
) (
  input logic clk_i,
  input logic reset_i,
  irq_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, HANDLER} state_t;
  localparam logic [XLEN-1:0] CAUSE_MEI = XLEN'(32'h8000_000B);
  localparam logic [XLEN-1:0] CAUSE_MSI = XLEN'(32'h8000_0003);
  localparam logic [XLEN-1:0] CAUSE_MTI = XLEN'(32'h8000_0007);
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   meip_q;
  logic                   mtip_q, mtip_d;
  logic                   msip_q, msip_d;
  logic [2:0]             ie_q, ie_d;
  logic                   mie_q, mie_d;
  logic                   mpie_q, mpie_d;
  logic                   req_q, req_d;
  logic [XLEN-1:0]        cause_q, cause_d;
  logic [XLEN-1:0]        rdata;
  logic [2:0]             eligible;
  logic [XLEN-1:0]        winner;
  logic                   take, ret, wr_ie, wr_status, wr_pend;
  logic                   unused_wdata;
  assign unused_wdata = ^{bus.csr_wdata[XLEN-1:12], bus.csr_wdata[10:8], bus.csr_wdata[6:4], bus.csr_wdata[2:0]};
  assign eligible  = {meip_q, mtip_q, msip_q} & ie_q & {3{mie_q}};
  assign winner    = eligible[2] ? CAUSE_MEI : eligible[0] ? CAUSE_MSI : CAUSE_MTI;
  assign take      = (state_q == REQ) && bus.irq_ack;
  assign ret       = (state_q == HANDLER) && bus.mret;
  assign wr_ie     = bus.csr_we && (bus.csr_sel == 2'd0);
  assign wr_status = bus.csr_we && (bus.csr_sel == 2'd1);
  assign wr_pend   = bus.csr_we && (bus.csr_sel == 2'd2);
  // Request FSM: latch the winner on entry to REQ and hold it untouched until the core acks
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cause_d = cause_q;
    unique case (state_q)
      IDLE: if (|eligible) begin
        state_d = REQ;
        req_d   = 1'b1;
        cause_d = winner;
      end
      REQ: if (bus.irq_ack) begin
        state_d = HANDLER;
        req_d   = 1'b0;
      end
      HANDLER: if (bus.mret) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // CSR and pending updates; trap entry/return override software STATUS writes, sources override clears
  always_comb begin
    ie_d   = wr_ie ? {bus.csr_wdata[11], bus.csr_wdata[7], bus.csr_wdata[3]} : ie_q;
    mie_d  = take ? 1'b0 : ret ? mpie_q : wr_status ? bus.csr_wdata[3] : mie_q;
    mpie_d = take ? mie_q : ret ? 1'b1 : wr_status ? bus.csr_wdata[7] : mpie_q;
    mtip_d = bus.timer_interrupt | (mtip_q & ~(take && cause_q == CAUSE_MTI));
    msip_d = bus.sw_irq_set | (wr_pend ? bus.csr_wdata[3] : msip_q & ~(take && cause_q == CAUSE_MSI));
  end
  // Register window read mux; unused bits and the reserved select read as zero
  always_comb begin
    rdata = '0;
    unique case (bus.csr_sel)
      2'd0: {rdata[11], rdata[7], rdata[3]} = ie_q;
      2'd1: {rdata[7], rdata[3]} = {mpie_q, mie_q};
      2'd2: {rdata[11], rdata[7], rdata[3]} = {meip_q, mtip_q, msip_q};
      default: ;
    endcase
  end
  assign bus.csr_rdata = rdata;
  assign bus.irq_req   = req_q;
  assign bus.irq_cause = cause_q;
  // State, CSR and synchroniser registers; MEIP is registered behind the sync chain
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      sync_q  <= '0;
      meip_q  <= 1'b0;
      mtip_q  <= 1'b0;
      msip_q  <= 1'b0;
      ie_q    <= '0;
      mie_q   <= 1'b0;
      mpie_q  <= 1'b0;
      req_q   <= 1'b0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.ext_irq};
      meip_q  <= sync_q[SYNC_STAGES-1];
      mtip_q  <= mtip_d;
      msip_q  <= msip_d;
      ie_q    <= ie_d;
      mie_q   <= mie_d;
      mpie_q  <= mpie_d;
      req_q   <= req_d;
      cause_q <= cause_d;
    end
  end
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed test-plan steps plus random traffic checked against a behavioural model
module tb_irq_controller;
  localparam int S = 2;
  localparam logic [31:0] MEI = 32'h8000_000B;
  localparam logic [31:0] MSI = 32'h8000_0003;
  localparam logic [31:0] MTI = 32'h8000_0007;
  logic clk;
  logic reset_n;
  int checks = 0;
  int errors = 0;
  logic [31:0] v;
  irq_controller_if #(.XLEN(32)) bus ();
  irq_controller #(.XLEN(32), .SYNC_STAGES(S)) dut (.clk_i(clk), .reset_i(reset_n), .bus(bus));
  initial clk = 1'b0;
  always #10 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  int          m_mode;
  int          m_src;
  logic        m_req;
  logic [31:0] m_cause;
  logic [2:0]  m_ie;
  logic [2:0]  m_pend;
  logic        m_mie;
  logic        m_mpie;
  logic        q_ext[$];
  function automatic logic [31:0] spread(input logic [2:0] b);
    logic [31:0] r;
    r = '0;
    r[11] = b[2];
    r[7] = b[1];
    r[3] = b[0];
    return r;
  endfunction
  function automatic logic [31:0] exp_rd(input int s);
    if (s == 0) return spread(m_ie);
    if (s == 1) return spread({1'b0, m_mpie, m_mie});
    if (s == 2) return spread(m_pend);
    return 32'h0;
  endfunction
  task automatic model_edge(input logic rn, tmr, ext, sw, we, input logic [1:0] sel,
                            input logic [31:0] wd, input logic ack, mret);
    logic [2:0] elig;
    logic take, ret, meip_new;
    int clr;
    int order[3];
    order = '{2, 0, 1};
    clr = -1;
    if (!rn) begin
      m_mode = 0; m_src = -1; m_req = 0; m_cause = 0;
      m_ie = 0; m_pend = 0; m_mie = 0; m_mpie = 0;
      q_ext.delete();
      for (int k = 0; k < S; k++) q_ext.push_back(1'b0);
      return;
    end
    q_ext.push_back(ext);
    meip_new = q_ext.pop_front();
    elig = m_mie ? (m_pend & m_ie) : 3'b000;
    take = (m_mode == 1) && ack;
    ret = (m_mode == 2) && mret;
    if (m_mode == 0 && elig != 0) begin
      for (int k = 2; k >= 0; k--) if (elig[order[k]]) m_src = order[k];
      m_cause = (m_src == 2) ? MEI : (m_src == 0) ? MSI : MTI;
      m_req = 1;
      m_mode = 1;
    end else if (take) begin
      clr = m_src;
      m_req = 0;
      m_mode = 2;
    end else if (ret) m_mode = 0;
    if (take) begin
      m_mpie = m_mie;
      m_mie = 0;
    end else if (ret) begin
      m_mie = m_mpie;
      m_mpie = 1;
    end else if (we && sel == 1) begin
      m_mpie = wd[7];
      m_mie = wd[3];
    end
    if (we && sel == 0) m_ie = {wd[11], wd[7], wd[3]};
    m_pend[1] = tmr | (m_pend[1] && clr != 1);
    m_pend[0] = sw | ((we && sel == 2) ? wd[3] : (m_pend[0] && clr != 0));
    m_pend[2] = meip_new;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    logic rn, tmr, ext, sw, we, ack, mret;
    logic [1:0] sel;
    logic [31:0] wd;
    rn = reset_n; tmr = bus.timer_interrupt; ext = bus.ext_irq; sw = bus.sw_irq_set;
    we = bus.csr_we; sel = bus.csr_sel; wd = bus.csr_wdata; ack = bus.irq_ack; mret = bus.mret;
    @(posedge clk);
    model_edge(rn, tmr, ext, sw, we, sel, wd, ack, mret);
    #1;
    bus.timer_interrupt = 0; bus.sw_irq_set = 0; bus.csr_we = 0; bus.irq_ack = 0; bus.mret = 0;
    chk("req", {31'b0, bus.irq_req}, {31'b0, m_req});
    if (m_req) chk("cause", bus.irq_cause, m_cause);
    for (int s = 0; s < 4; s++) begin
      bus.csr_sel = 2'(s);
      #1;
      chk($sformatf("rdata%0d", s), bus.csr_rdata, exp_rd(s));
    end
  endtask
  task automatic wr(input logic [1:0] s, input logic [31:0] d);
    bus.csr_we = 1; bus.csr_sel = s; bus.csr_wdata = d;
    tick();
  endtask
  task automatic rd(input logic [1:0] s, output logic [31:0] r);
    bus.csr_sel = s;
    #1;
    r = bus.csr_rdata;
  endtask
  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask
  initial begin
    bus.timer_interrupt = 0; bus.ext_irq = 0; bus.sw_irq_set = 0; bus.csr_we = 0;
    bus.csr_sel = 0; bus.csr_wdata = 0; bus.irq_ack = 0; bus.mret = 0;
    reset_n = 0;
    ticks(3);
    chk("rst_req", {31'b0, bus.irq_req}, 32'h0);
    chk("rst_cause", bus.irq_cause, 32'h0);
    reset_n = 1;
    wr(0, 32'h80);
    wr(1, 32'h08);
    ticks(2);
    bus.timer_interrupt = 1;
    tick();
    chk("tmr_lat1", {31'b0, bus.irq_req}, 32'h0);
    tick();
    chk("tmr_lat2", {31'b0, bus.irq_req}, 32'h1);
    chk("tmr_cause", bus.irq_cause, MTI);
    ticks(3);
    chk("tmr_hold", {31'b0, bus.irq_req}, 32'h1);
    bus.irq_ack = 1;
    tick();
    chk("ack_drop", {31'b0, bus.irq_req}, 32'h0);
    rd(2, v);
    chk("ack_mtip", v & 32'h80, 32'h0);
    rd(1, v);
    chk("ack_status", v, 32'h80);
    bus.mret = 1;
    tick();
    rd(1, v);
    chk("mret_status", v, 32'h88);
    bus.timer_interrupt = 1;
    ticks(2);
    chk("tmr_again", {31'b0, bus.irq_req}, 32'h1);
    chk("tmr_again_cause", bus.irq_cause, MTI);
    bus.irq_ack = 1;
    tick();
    bus.mret = 1;
    tick();
    wr(1, 32'h0);
    wr(0, 32'h888);
    bus.ext_irq = 1; bus.sw_irq_set = 1;
    ticks(5);
    wr(1, 32'h08);
    chk("mie_gate", {31'b0, bus.irq_req}, 32'h0);
    tick();
    chk("prio_mei", bus.irq_cause, MEI);
    bus.irq_ack = 1;
    tick();
    bus.mret = 1;
    tick();
    tick();
    chk("mei_again_req", {31'b0, bus.irq_req}, 32'h1);
    chk("mei_again", bus.irq_cause, MEI);
    bus.irq_ack = 1;
    tick();
    bus.ext_irq = 0;
    ticks(4);
    bus.mret = 1;
    tick();
    tick();
    chk("msi_req", {31'b0, bus.irq_req}, 32'h1);
    chk("msi_cause", bus.irq_cause, MSI);
    bus.irq_ack = 1;
    tick();
    bus.mret = 1;
    ticks(2);
    chk("idle_quiet", {31'b0, bus.irq_req}, 32'h0);
    rd(2, v);
    chk("pend_clear", v, 32'h0);
    wr(1, 32'h0);
    wr(0, 32'h80);
    bus.timer_interrupt = 1;
    ticks(3);
    chk("mie0_noreq", {31'b0, bus.irq_req}, 32'h0);
    rd(2, v);
    chk("mie0_mtip", v, 32'h80);
    wr(1, 32'h08);
    chk("mie_on_edge", {31'b0, bus.irq_req}, 32'h0);
    tick();
    chk("mie_on_req", {31'b0, bus.irq_req}, 32'h1);
    chk("mie_on_cause", bus.irq_cause, MTI);
    bus.irq_ack = 1;
    tick();
    bus.mret = 1;
    tick();
    wr(0, 32'h800);
    bus.ext_irq = 1;
    for (int k = 0; k < 10 && !bus.irq_req; k++) tick();
    chk("ext_req", {31'b0, bus.irq_req}, 32'h1);
    chk("ext_cause", bus.irq_cause, MEI);
    wr(0, 32'h0);
    bus.ext_irq = 0;
    ticks(4);
    chk("hold_req", {31'b0, bus.irq_req}, 32'h1);
    chk("hold_cause", bus.irq_cause, MEI);
    bus.irq_ack = 1;
    tick();
    reset_n = 0;
    tick();
    reset_n = 1;
    chk("rst_h_req", {31'b0, bus.irq_req}, 32'h0);
    chk("rst_h_cause", bus.irq_cause, 32'h0);
    for (int s = 0; s < 3; s++) begin
      rd(2'(s), v);
      chk($sformatf("rst_h_csr%0d", s), v, 32'h0);
    end
    bus.mret = 1;
    tick();
    rd(1, v);
    chk("late_mret", v, 32'h0);
    chk("late_mret_req", {31'b0, bus.irq_req}, 32'h0);
    for (int i = 0; i < 800; i++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 11) == 0) bus.ext_irq = ~bus.ext_irq;
      bus.timer_interrupt = ($urandom_range(0, 5) == 0);
      bus.sw_irq_set = ($urandom_range(0, 7) == 0);
      bus.csr_we = ($urandom_range(0, 4) == 0);
      bus.csr_sel = 2'($urandom_range(0, 3));
      bus.csr_wdata = $urandom;
      bus.irq_ack = ($urandom_range(0, 2) == 0);
      bus.mret = ($urandom_range(0, 4) == 0);
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
